// File: rtl/lr35902_dma.sv
// OAM DMA engine for the 0xFF46 register: copies LEN bytes from page {EP,00} into OAM.
// Optional register readback is enabled by defining LR35902_DMA_READBACK_EN.
module lr35902_dma #(
   parameter int         LEN          = 160,
   parameter int         CPB          = 4,
   parameter logic [7:0] VRAM_PAGE_LO = 8'h80,
   parameter logic [7:0] VRAM_PAGE_HI = 8'h9F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write,
   input  logic        reg_read,
   input  logic [7:0]  reg_din,
   output logic [7:0]  reg_dout,
   output logic        active,
   output logic        drvext,
   output logic [15:0] adr_rd,
   output logic        rd,
   input  logic [7:0]  data_in,
   output logic [7:0]  adr_wr,
   output logic        wr,
   output logic [7:0]  data_out,
   output logic        done
);

   localparam int              PH_W    = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CPB - 1);
   localparam logic [8:0]      I_LAST  = 9'(LEN - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, XFER = 2'd2} state_t;

   state_t          state_reg, state_next;
   logic [7:0]      ep_reg;
   logic [8:0]      i_reg;
   logic [PH_W-1:0] ph_reg;
   logic [7:0]      data_out_reg;
   logic            done_reg;
   logic [7:0]      ep_fold;
   logic            last_slot;
   logic            in_vram;

   // Pages E0..FF are the echo of C0..DF on the source side.
   assign ep_fold   = (reg_din >= 8'hE0) ? (reg_din & 8'hDF) : reg_din;
   assign last_slot = (state_reg == XFER) && (ph_reg == PH_LAST) && (i_reg == I_LAST);
   assign in_vram   = (ep_reg >= VRAM_PAGE_LO) && (ep_reg <= VRAM_PAGE_HI);

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (reg_write)
         state_next = START;
      else begin
         case (state_reg)
            START:   state_next = XFER;
            XFER:    if (last_slot) state_next = IDLE;
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin
      active = (state_reg != IDLE) || done_reg;
      rd     = (state_reg == XFER) && (ph_reg == PH_W'(0));
      wr     = (state_reg == XFER) && (ph_reg == PH_W'(2)) && !reg_write;
      drvext = active && !in_vram;
   end

   // Index holds at LEN-1 on the final wrap so adr_wr never leaves the OAM range.
   always_ff @(posedge clk) begin
      if (reset) begin
         ep_reg       <= 8'h00;
         i_reg        <= 9'd0;
         ph_reg       <= '0;
         data_out_reg <= 8'h00;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= last_slot && !reg_write;
         if (reg_write) begin
            ep_reg <= ep_fold;
            i_reg  <= 9'd0;
            ph_reg <= '0;
         end else if (state_reg == XFER) begin
            if (ph_reg == PH_LAST) begin
               ph_reg <= '0;
               if (i_reg != I_LAST)
                  i_reg <= i_reg + 9'd1;
            end else begin
               ph_reg <= ph_reg + PH_W'(1);
            end
         end
         if ((state_reg == XFER) && (ph_reg == PH_W'(1)))
            data_out_reg <= data_in;
      end
   end

   assign adr_rd   = {ep_reg, i_reg[7:0]};
   assign adr_wr   = i_reg[7:0];
   assign data_out = data_out_reg;
   assign done     = done_reg;

`ifdef LR35902_DMA_READBACK_EN
   logic [7:0] page_reg;
   logic [7:0] dout_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         page_reg <= 8'h00;
         dout_reg <= 8'h00;
      end else begin
         if (reg_write)
            page_reg <= reg_din;
         if (reg_read)
            dout_reg <= page_reg;
      end
   end

   assign reg_dout = dout_reg;
`else
   logic unused_reg_read;
   assign unused_reg_read = reg_read;
   assign reg_dout        = 8'hFF;
`endif

endmodule

// File: tb/tb_lr35902_dma.sv
// Directed bench for lr35902_dma: default instance plus a LEN=256/CPB=3 instance.
module tb_lr35902_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        reg_write, reg_read;
   logic [7:0]  reg_din, reg_dout;
   logic        active, drvext, rd, wr, done;
   logic [15:0] adr_rd;
   logic [7:0]  data_in, adr_wr, data_out;

   logic        reg_write2, reg_read2;
   logic [7:0]  reg_din2, reg_dout2;
   logic        active2, drvext2, rd2, wr2, done2;
   logic [15:0] adr_rd2;
   logic [7:0]  data_in2, adr_wr2, data_out2;

   logic [7:0]  oam  [0:255];
   logic [7:0]  oam2 [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lr35902_dma dut (
      .clk(clk), .reset(reset), .reg_write(reg_write), .reg_read(reg_read),
      .reg_din(reg_din), .reg_dout(reg_dout), .active(active), .drvext(drvext),
      .adr_rd(adr_rd), .rd(rd), .data_in(data_in), .adr_wr(adr_wr), .wr(wr),
      .data_out(data_out), .done(done)
   );

   lr35902_dma #(.LEN(256), .CPB(3)) dut2 (
      .clk(clk), .reset(reset), .reg_write(reg_write2), .reg_read(reg_read2),
      .reg_din(reg_din2), .reg_dout(reg_dout2), .active(active2), .drvext(drvext2),
      .adr_rd(adr_rd2), .rd(rd2), .data_in(data_in2), .adr_wr(adr_wr2), .wr(wr2),
      .data_out(data_out2), .done(done2)
   );

   // Registered source memory: byte k holds k^5A; output is zero when not read.
   always @(posedge clk) begin
      data_in  <= rd  ? (adr_rd[7:0]  ^ 8'h5A) : 8'h00;
      data_in2 <= rd2 ? (adr_rd2[7:0] ^ 8'h5A) : 8'h00;
      if (wr)  oam[adr_wr]   <= data_out;
      if (wr2) oam2[adr_wr2] <= data_out2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Pulses reg_write for one cycle; returns wr as seen during the write cycle.
   task automatic do_write(input logic [7:0] p, output logic wr_seen);
      @(negedge clk);
      reg_write = 1'b1;
      reg_din   = p;
      #1 wr_seen = wr;
      @(negedge clk);
      reg_write = 1'b0;
   endtask

   // Starts at cycle 1 after a write; returns the cycle count at which done was seen.
   task automatic run_xfer(input int bound, output int lat, output logic [15:0] first_adr,
                           output logic [15:0] last_adr, output int nwr,
                           output logic drv_or, output logic drv_and);
      logic seen;
      seen = 1'b0; lat = 1; nwr = 0; drv_or = 1'b0; drv_and = 1'b1;
      first_adr = 16'h0; last_adr = 16'h0;
      forever begin
         if (rd) begin
            if (!seen) first_adr = adr_rd;
            seen = 1'b1;
            last_adr = adr_rd;
         end
         if (wr) nwr++;
         if (active) begin
            drv_or  = drv_or | drvext;
            drv_and = drv_and & drvext;
         end
         if (done || lat >= bound) break;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic clear_oam();
      for (int k = 0; k < 256; k++) begin
         oam[k]  = 8'h00;
         oam2[k] = 8'h00;
      end
   endtask

   initial begin
      int          lat, nwr, errs, cnt, max_wr;
      logic [15:0] fa, la;
      logic        dor, dand, wseen;
      logic [7:0]  exp_rb;

      reset = 1'b1; reg_write = 1'b0; reg_read = 1'b0; reg_din = 8'h00;
      reg_write2 = 1'b0; reg_read2 = 1'b0; reg_din2 = 8'h00;
      clear_oam();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_active",   active,   0);
      check("rst_drvext",   drvext,   0);
      check("rst_rd_wr",    {rd, wr}, 0);
      check("rst_done",     done,     0);
      check("rst_adr_rd",   adr_rd,   0);
      check("rst_adr_wr",   adr_wr,   0);
      check("rst_data_out", data_out, 0);
`ifdef LR35902_DMA_READBACK_EN
      check("rst_reg_dout", reg_dout, 8'h00);
`else
      check("rst_reg_dout", reg_dout, 8'hFF);
`endif

      // Basic transfer from C1xx
      do_write(8'hC1, wseen);
      check("c1_active_next", active, 1);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      check("c1_latency", lat, 642);
      check("c1_active_at_done", active, 1);
      check("c1_first_adr", fa, 16'hC100);
      check("c1_last_adr", la, 16'hC19F);
      check("c1_wr_count", nwr, 160);
      check("c1_drvext", dand, 1);
      @(negedge clk);
      check("c1_active_after", active, 0);
      errs = 0;
      for (int k = 0; k < 160; k++)
         if (oam[k] !== (8'(k) ^ 8'h5A)) errs++;
      check("c1_oam_errors", errs, 0);

      // VRAM source, with reg_read held high throughout
      reg_read = 1'b1;
      do_write(8'h88, wseen);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      reg_read = 1'b0;
      check("p88_latency", lat, 642);
      check("p88_drvext_any", dor, 0);
      check("p88_first_adr", fa, 16'h8800);
      check("p88_last_adr", la, 16'h889F);

      // Echo fold; readback returns P, not EP
      do_write(8'hFE, wseen);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      check("pfe_first_adr", fa, 16'hDE00);
      check("pfe_drvext", dand, 1);
      @(negedge clk);
      reg_read = 1'b1;
      @(negedge clk);
      reg_read = 1'b0;
`ifdef LR35902_DMA_READBACK_EN
      exp_rb = 8'hFE;
`else
      exp_rb = 8'hFF;
`endif
      check("pfe_readback", reg_dout, exp_rb);

      // Abort at cycle 100 (a write phase) with a new page
      do_write(8'hC0, wseen);
      repeat (98) @(negedge clk);
      do_write(8'hD0, wseen);
      check("abort_wr_suppressed", wseen, 0);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      check("abort_latency", lat, 642);
      check("abort_first_adr", fa, 16'hD000);
      check("abort_wr_count", nwr, 160);

      // Abort colliding with the final write at cycle 640
      do_write(8'hC1, wseen);
      repeat (638) @(negedge clk);
      do_write(8'hC2, wseen);
      check("final_abort_wr", wseen, 0);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      check("final_abort_latency", lat, 642);

      // Reset at cycle 50 of a transfer
      do_write(8'hC1, wseen);
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_active", active, 0);
      check("midrst_rd_wr", {rd, wr}, 0);
      reset = 1'b0;
      cnt = 0;
      repeat (700) begin
         @(negedge clk);
         if (done || rd || wr) cnt++;
      end
      check("midrst_quiet", cnt, 0);
      do_write(8'h12, wseen);
      run_xfer(1000, lat, fa, la, nwr, dor, dand);
      check("midrst_restart_adr", fa, 16'h1200);
      check("midrst_restart_lat", lat, 642);

      // LEN=256, CPB=3 instance
      @(negedge clk);
      reg_write2 = 1'b1; reg_din2 = 8'hC1;
      @(negedge clk);
      reg_write2 = 1'b0;
      lat = 1; max_wr = 0; nwr = 0; cnt = 0;
      while (!done2 && lat < 1200) begin
         if (wr2) begin
            nwr++;
            if (int'(adr_wr2) > max_wr) max_wr = int'(adr_wr2);
            if (int'(adr_wr2) != (nwr - 1)) cnt++;
         end
         @(negedge clk);
         lat++;
      end
      check("l256_latency", lat, 770);
      check("l256_max_adr_wr", max_wr, 255);
      check("l256_wr_count", nwr, 256);
      check("l256_order_errors", cnt, 0);
      errs = 0;
      for (int k = 0; k < 256; k++)
         if (oam2[k] !== (8'(k) ^ 8'h5A)) errs++;
      check("l256_oam_errors", errs, 0);
      @(negedge clk);
      check("l256_active_after", active2, 0);

      @(negedge clk);
      reg_write2 = 1'b1; reg_din2 = 8'hAB;
      @(negedge clk);
      reg_write2 = 1'b0; reg_read2 = 1'b1;
      @(negedge clk);
      reg_read2 = 1'b0;
`ifdef LR35902_DMA_READBACK_EN
      exp_rb = 8'hAB;
`else
      exp_rb = 8'hFF;
`endif
      check("l256_readback", reg_dout2, exp_rb);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
